conv1d_ctrl: RTL and testbench



---
 rtl/conv1d_pkg.sv | 27 ++
 rtl/conv1d_vec_mem.sv | 26 ++
 rtl/conv1d_ctrl.sv | 158 +++++++++++++++
 tb/tb_conv1d_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv1d_pkg.sv
// Shared types and sizing helpers for the 1D convolution controller.
// Imported by the controller top and its vector memory.
package conv1d_pkg;

  localparam int DEF_WIDTH = 14;
  localparam int DEF_N = 8;
  localparam int ACC_W = 2 * DEF_WIDTH;
  localparam int CNT_W = $clog2(DEF_N + 1);

  typedef enum logic [2:0] {
    LOAD_W,
    LOAD_X,
    CLEAR,
    ISSUE,
    DRAIN,
    OUTPUT
  } state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/conv1d_vec_mem.sv
// Small register array: synchronous write, combinational read.
// Holds either the filter weights or the input samples.
module conv1d_vec_mem
  import conv1d_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 14,
  localparam int AW = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/conv1d_ctrl.sv
// Loads a filter and a sample vector, then sequences a pipelined
// saturating MAC over every valid output point and streams results.
module conv1d_ctrl
  import conv1d_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int N = 8,
  parameter int M = 4,
  parameter int MULT_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WIDTH-1:0]   s_data,
  output logic [WIDTH-1:0]   mac_a,
  output logic [WIDTH-1:0]   mac_b,
  output logic               mac_enable_mult,
  output logic               mac_en_pipeline_reg,
  output logic               mac_en_acc,
  output logic               mac_clear_acc,
  input  logic [2*WIDTH-1:0] mac_f,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [2*WIDTH-1:0] m_data
);

  localparam int CW = cnt_w(N);
  localparam int WAW = addr_w(M);
  localparam int XAW = addr_w(N);
  localparam int DW = cnt_w(MULT_STAGES + 1);

  state_t state, state_d;

  logic [CW-1:0] wk, xj, i, k;
  logic [DW-1:0] dcnt;
  logic [MULT_STAGES-1:0] vsr;
  logic [MULT_STAGES:0] vd;
  logic v, s_fire, m_fire;
  logic last_w, last_x, last_k;
  logic last_d, last_i;
  logic [WIDTH-1:0] w_rd, x_rd;

  assign s_fire = s_valid && s_ready;
  assign m_fire = m_valid && m_ready;

  assign last_w = wk == CW'(M - 1);
  assign last_x = xj == CW'(N - 1);
  assign last_k = k == CW'(M - 1);
  assign last_d = dcnt == DW'(MULT_STAGES);
  assign last_i = i == CW'(N - M);

  conv1d_vec_mem #(
    .DEPTH(M),
    .WIDTH(WIDTH)
  ) u_w_mem (
    .clk  (clk),
    .we   (s_fire && state == LOAD_W),
    .waddr(WAW'(wk)),
    .wdata(s_data),
    .raddr(WAW'(k)),
    .rdata(w_rd)
  );

  conv1d_vec_mem #(
    .DEPTH(N),
    .WIDTH(WIDTH)
  ) u_x_mem (
    .clk  (clk),
    .we   (s_fire && state == LOAD_X),
    .waddr(XAW'(xj)),
    .wdata(s_data),
    .raddr(XAW'(i + k)),
    .rdata(x_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD_W;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    s_ready = 1'b0;
    v = 1'b0;
    mac_clear_acc = 1'b0;
    if (!reset) begin
      unique case (state)
        LOAD_W: begin
          s_ready = 1'b1;
          if (s_valid && last_w) state_d = LOAD_X;
        end
        LOAD_X: begin
          s_ready = 1'b1;
          if (s_valid && last_x) state_d = CLEAR;
        end
        CLEAR: begin
          mac_clear_acc = 1'b1;
          state_d = ISSUE;
        end
        ISSUE: begin
          v = 1'b1;
          if (last_k) state_d = DRAIN;
        end
        DRAIN: begin
          if (last_d) state_d = OUTPUT;
        end
        OUTPUT: begin
          if (m_fire) state_d = last_i ? LOAD_W : CLEAR;
        end
        default: state_d = LOAD_W;
      endcase
    end
  end

  // vd[d] is the issue-valid delayed by d cycles
  assign vd = {vsr, v};
  assign mac_enable_mult = v;
  assign mac_en_pipeline_reg = vd[MULT_STAGES-1] && !reset;
  assign mac_en_acc = vd[MULT_STAGES] && !reset;
  assign mac_a = v ? x_rd : '0;
  assign mac_b = v ? w_rd : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wk <= '0;
      xj <= '0;
      i <= '0;
      k <= '0;
      dcnt <= '0;
      vsr <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
    end else begin
      vsr <= vd[MULT_STAGES-1:0];
      if (state == LOAD_W && s_fire)
        wk <= last_w ? '0 : wk + 1'b1;
      if (state == LOAD_X && s_fire) begin
        xj <= last_x ? '0 : xj + 1'b1;
        if (last_x) i <= '0;
      end
      if (state == ISSUE)
        k <= last_k ? '0 : k + 1'b1;
      if (state == DRAIN) begin
        dcnt <= last_d ? '0 : dcnt + 1'b1;
        if (last_d) begin
          m_data <= mac_f;
          m_valid <= 1'b1;
        end
      end
      if (m_fire) begin
        m_valid <= 1'b0;
        if (!last_i) i <= i + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv1d_ctrl.sv
// Directed bench for conv1d_ctrl with a behavioural saturating MAC
// (2-stage multiplier path, 28-bit saturating accumulator).
module tb_conv1d_ctrl;
  import conv1d_pkg::*;

  localparam int W = 14;
  localparam int N = 8;
  localparam int M = 4;
  localparam int MS = 2;
  localparam int AW = ACC_W;

  logic clk, reset;
  logic s_valid, s_ready;
  logic [W-1:0] s_data;
  logic [W-1:0] mac_a, mac_b;
  logic mac_enable_mult, mac_en_pipeline_reg;
  logic mac_en_acc, mac_clear_acc;
  logic [AW-1:0] mac_f;
  logic m_valid, m_ready;
  logic [AW-1:0] m_data;

  int n_cmp, n_err;
  int wbuf[M];
  int xbuf[N];
  int exp_basic[5] = '{30, 40, 50, 60, 70};

  conv1d_ctrl #(
    .WIDTH(W), .N(N), .M(M), .MULT_STAGES(MS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .mac_a(mac_a),
    .mac_b(mac_b),
    .mac_enable_mult(mac_enable_mult),
    .mac_en_pipeline_reg(mac_en_pipeline_reg),
    .mac_en_acc(mac_en_acc),
    .mac_clear_acc(mac_clear_acc),
    .mac_f(mac_f),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural MAC model
  logic signed [AW-1:0] p1, p2, acc;
  logic signed [AW:0] sum;
  assign sum = {acc[AW-1], acc} + {p2[AW-1], p2};
  assign mac_f = acc;

  always @(posedge clk) begin
    if (reset) begin
      p1 <= '0;
      p2 <= '0;
      acc <= '0;
    end else begin
      if (mac_enable_mult)
        p1 <= $signed(mac_a) * $signed(mac_b);
      if (mac_en_pipeline_reg) p2 <= p1;
      if (mac_clear_acc) acc <= '0;
      else if (mac_en_acc) begin
        if (sum[AW] != sum[AW-1])
          acc <= sum[AW] ? {1'b1, {(AW-1){1'b0}}}
                         : {1'b0, {(AW-1){1'b1}}};
        else
          acc <= sum[AW-1:0];
      end
    end
  end

  task automatic send_word(input logic [W-1:0] d);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data = d;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: s_ready=%0b required 1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic load_job(input bit gap);
    for (int j = 0; j < M + N; j++) begin
      if (j < M) send_word(W'(wbuf[j]));
      else       send_word(W'(xbuf[j-M]));
      if (gap) begin
        s_data = 14'h2AAA;
        @(negedge clk);
      end
    end
  endtask

  task automatic get_result(output logic [AW-1:0] d, output bit ok);
    int n;
    n = 0;
    while (!m_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = m_valid;
    d = m_data;
    if (ok) @(negedge clk);
  endtask

  task automatic set_basic();
    for (int j = 0; j < M; j++) wbuf[j] = j + 1;
    for (int j = 0; j < N; j++) xbuf[j] = j + 1;
  endtask

  task automatic check_basic_run(input string tag);
    logic [AW-1:0] d;
    bit ok;
    for (int j = 0; j < 5; j++) begin
      get_result(d, ok);
      n_cmp++;
      if (!ok || d !== AW'(exp_basic[j])) begin
        n_err++;
        $display("FAIL %s y%0d: got %0d ok=%0b required %0d",
                 tag, j, d, ok, exp_basic[j]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_s_ready: got %0b required 0", s_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL post_rst_s_ready: got %0b required 1", s_ready);
    end
    n_cmp++;
    if (m_valid !== 1'b0 || m_data !== '0) begin
      n_err++;
      $display("FAIL rst_m: m_valid=%0b m_data=%0d required 0/0",
               m_valid, m_data);
    end
    n_cmp++;
    if ({mac_a, mac_b} !== '0) begin
      n_err++;
      $display("FAIL rst_operands: got %h required 0", {mac_a, mac_b});
    end
    n_cmp++;
    if ({mac_enable_mult, mac_en_pipeline_reg,
         mac_en_acc, mac_clear_acc} !== 4'b0) begin
      n_err++;
      $display("FAIL rst_enables: got %b required 0000",
               {mac_enable_mult, mac_en_pipeline_reg,
                mac_en_acc, mac_clear_acc});
    end
  endtask

  task automatic test_basic();
    m_ready = 1'b1;
    set_basic();
    load_job(1'b0);
    check_basic_run("basic");
    n_cmp++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_end: s_ready=%0b m_valid=%0b required 1/0",
               s_ready, m_valid);
    end
  endtask

  task automatic test_backpressure();
    int n;
    m_ready = 1'b0;
    set_basic();
    load_job(1'b0);
    n = 0;
    while (!m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (m_valid !== 1'b1 || m_data !== AW'(30)) begin
        n_err++;
        $display("FAIL bp_hold c%0d: valid=%0b data=%0d required 1/30",
                 c, m_valid, m_data);
      end
      n_cmp++;
      if (mac_clear_acc !== 1'b0 || mac_enable_mult !== 1'b0) begin
        n_err++;
        $display("FAIL bp_idle c%0d: clr=%0b mult=%0b required 0/0",
                 c, mac_clear_acc, mac_enable_mult);
      end
      @(negedge clk);
    end
    m_ready = 1'b1;
    check_basic_run("bp");
  endtask

  task automatic test_saturate();
    logic [AW-1:0] d;
    bit ok;
    m_ready = 1'b1;
    for (int j = 0; j < M; j++) wbuf[j] = -8192;
    for (int j = 0; j < N; j++) xbuf[j] = -8192;
    load_job(1'b0);
    for (int j = 0; j < 5; j++) begin
      get_result(d, ok);
      n_cmp++;
      if (!ok || d !== 28'h7FFFFFF) begin
        n_err++;
        $display("FAIL sat y%0d: got %h ok=%0b required 7ffffff",
                 j, d, ok);
      end
    end
  endtask

  task automatic test_gaps();
    m_ready = 1'b1;
    set_basic();
    load_job(1'b1);
    check_basic_run("gaps");
  endtask

  task automatic test_align();
    int cyc, t_clr, t_iss, t_pipe, t_acc, t_acc_l;
    int n_acc, n_mult;
    m_ready = 1'b1;
    set_basic();
    load_job(1'b0);
    cyc = 0;
    t_clr = -1;
    t_iss = -1;
    t_pipe = -1;
    t_acc = -1;
    t_acc_l = -1;
    n_acc = 0;
    n_mult = 0;
    while (!m_valid && cyc < 40) begin
      if (mac_clear_acc && t_clr < 0) t_clr = cyc;
      if (mac_enable_mult) begin
        n_mult++;
        if (t_iss < 0) t_iss = cyc;
      end
      if (mac_en_pipeline_reg && t_pipe < 0) t_pipe = cyc;
      if (mac_en_acc) begin
        n_acc++;
        t_acc_l = cyc;
        if (t_acc < 0) t_acc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (n_acc !== M || t_acc_l - t_acc !== M - 1) begin
      n_err++;
      $display("FAIL acc_pulses: count=%0d span=%0d required %0d/%0d",
               n_acc, t_acc_l - t_acc, M, M - 1);
    end
    n_cmp++;
    if (n_mult !== M) begin
      n_err++;
      $display("FAIL mult_pulses: got %0d required %0d", n_mult, M);
    end
    n_cmp++;
    if (t_acc - t_iss !== MS) begin
      n_err++;
      $display("FAIL acc_delay: got %0d required %0d", t_acc - t_iss, MS);
    end
    n_cmp++;
    if (t_pipe - t_iss !== MS - 1) begin
      n_err++;
      $display("FAIL pipe_delay: got %0d required %0d",
               t_pipe - t_iss, MS - 1);
    end
    n_cmp++;
    if (t_iss - t_clr !== 1 || cyc - t_clr !== 8) begin
      n_err++;
      $display("FAIL latency: issue=%0d valid=%0d required 1/8",
               t_iss - t_clr, cyc - t_clr);
    end
    check_basic_run("align");
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] d;
    bit ok;
    int n;
    m_ready = 1'b1;
    set_basic();
    load_job(1'b0);
    get_result(d, ok);
    n_cmp++;
    if (!ok || d !== AW'(30)) begin
      n_err++;
      $display("FAIL mid_first: got %0d ok=%0b required 30", d, ok);
    end
    n = 0;
    while (!mac_enable_mult && n < 50) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_rst: m_valid=%0b s_ready=%0b required 0/1",
               m_valid, s_ready);
    end
    wbuf = '{1, 0, 0, 0};
    for (int j = 0; j < N; j++) xbuf[j] = j + 5;
    load_job(1'b0);
    for (int j = 0; j < 5; j++) begin
      get_result(d, ok);
      n_cmp++;
      if (!ok || d !== AW'(j + 5)) begin
        n_err++;
        $display("FAIL mid_new y%0d: got %0d ok=%0b required %0d",
                 j, d, ok, j + 5);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_saturate();
    test_gaps();
    test_align();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
